// File: rtl/vga_lane_overlay.sv
// VGA sync/address generator with frame-locked screen select and
// per-lane note boxes (level colour, white flash on new hit).
// Ports: iVGA_CLK/iRST_n clock and async low reset; iScreen requested
// background; iLanes 2-bit level per lane; iPixel_bgr ROM data
// PIX_LAT cycles after oADDR; oADDR frame-buffer address; oScreen
// frame-stable screen; oHS/oVS/oBLANK_n sync and blank (active low);
// b_data/g_data/r_data output colour.
module vga_lane_overlay #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int PIX_LAT      = 2,
  parameter int NUM_LANES    = 4,
  parameter int LANE_X0      = 155,
  parameter int LANE_PITCH   = 80,
  parameter int LANE_W       = 38,
  parameter int LANE_Y0      = 199,
  parameter int LANE_H       = 48,
  parameter int FLASH_FRAMES = 6
) (
  input  logic                   iVGA_CLK,
  input  logic                   iRST_n,
  input  logic [1:0]             iScreen,
  input  logic [2*NUM_LANES-1:0] iLanes,
  input  logic [23:0]            iPixel_bgr,
  output logic [18:0]            oADDR,
  output logic [1:0]             oScreen,
  output logic                   oHS,
  output logic                   oVS,
  output logic                   oBLANK_n,
  output logic [7:0]             b_data,
  output logic [7:0]             g_data,
  output logic [7:0]             r_data
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int HS0 = H_ACTIVE + H_FP;
  localparam int VS0 = V_ACTIVE + V_FP;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [18:0]   addr_q, addr_d;
  logic [1:0]    screen_q, screen_d;
  logic [2*NUM_LANES-1:0] lanes_q, lanes_d;
  logic [7:0]    flash_q [NUM_LANES];
  logic [7:0]    flash_d [NUM_LANES];

  logic [PIX_LAT-1:0] act_q, hs_q, vs_q;
  logic [HW-1:0] x_q [PIX_LAT];
  logic [VW-1:0] y_q [PIX_LAT];

  logic          act_d, hs_d, vs_d;
  logic          h_last, v_last, frame_end;
  logic [31:0]   hc, vc, px, py;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_o_q, vs_o_q, blank_o_q;

  always_comb begin
    hc        = 32'(hcnt_q);
    vc        = 32'(vcnt_q);
    h_last    = hc == H_TOTAL - 1;
    v_last    = vc == V_TOTAL - 1;
    frame_end = h_last && v_last;
    hcnt_d    = h_last ? '0 : hcnt_q + 1'b1;
    vcnt_d    = vcnt_q;
    if (h_last)
      vcnt_d  = v_last ? '0 : vcnt_q + 1'b1;
    act_d     = (hc < H_ACTIVE) && (vc < V_ACTIVE);
    hs_d      = !((hc >= HS0) && (hc < HS0 + H_SYNC));
    vs_d      = !((vc >= VS0) && (vc < VS0 + V_SYNC));
    addr_d    = addr_q;
    if (frame_end)
      addr_d  = '0;
    else if (act_d)
      addr_d  = addr_q + 19'd1;
    screen_d  = frame_end ? iScreen : screen_q;
    lanes_d   = iLanes;
  end

  // A fresh hit reloads the counter even on a frame-end cycle.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      flash_d[i] = flash_q[i];
      if (frame_end && flash_q[i] != 8'd0)
        flash_d[i] = flash_q[i] - 8'd1;
      if (lanes_q[2*i +: 2] == 2'd0 &&
          iLanes[2*i +: 2] != 2'd0)
        flash_d[i] = 8'(FLASH_FRAMES);
    end
  end

  // Descending scan so the lowest-index box wins on overlap.
  always_comb begin
    px    = 32'(x_q[PIX_LAT-1]);
    py    = 32'(y_q[PIX_LAT-1]);
    rgb_d = iPixel_bgr;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (px >= LANE_X0 + i*LANE_PITCH &&
          px <  LANE_X0 + i*LANE_PITCH + LANE_W &&
          py >= LANE_Y0 && py < LANE_Y0 + LANE_H) begin
        rgb_d = iPixel_bgr;
        if (flash_q[i] != 8'd0)
          rgb_d = 24'hFFFFFF;
        else begin
          case (lanes_q[2*i +: 2])
            2'd3:    rgb_d = 24'h006400;
            2'd2:    rgb_d = 24'h32CD32;
            2'd1:    rgb_d = 24'h90EE90;
            default: rgb_d = iPixel_bgr;
          endcase
        end
      end
    end
    if (!act_q[PIX_LAT-1])
      rgb_d = 24'h000000;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      addr_q    <= '0;
      screen_q  <= '0;
      lanes_q   <= '0;
      act_q     <= '0;
      hs_q      <= '1;
      vs_q      <= '1;
      rgb_q     <= '0;
      hs_o_q    <= 1'b1;
      vs_o_q    <= 1'b1;
      blank_o_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++)
        flash_q[i] <= '0;
      for (int i = 0; i < PIX_LAT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      addr_q    <= addr_d;
      screen_q  <= screen_d;
      lanes_q   <= lanes_d;
      for (int i = 0; i < NUM_LANES; i++)
        flash_q[i] <= flash_d[i];
      act_q[0]  <= act_d;
      hs_q[0]   <= hs_d;
      vs_q[0]   <= vs_d;
      x_q[0]    <= hcnt_q;
      y_q[0]    <= vcnt_q;
      for (int i = 1; i < PIX_LAT; i++) begin
        act_q[i] <= act_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
        x_q[i]   <= x_q[i-1];
        y_q[i]   <= y_q[i-1];
      end
      rgb_q     <= rgb_d;
      hs_o_q    <= hs_q[PIX_LAT-1];
      vs_o_q    <= vs_q[PIX_LAT-1];
      blank_o_q <= act_q[PIX_LAT-1];
    end
  end

  assign oADDR    = addr_q;
  assign oScreen  = screen_q;
  assign oHS      = hs_o_q;
  assign oVS      = vs_o_q;
  assign oBLANK_n = blank_o_q;
  assign b_data   = rgb_q[23:16];
  assign g_data   = rgb_q[15:8];
  assign r_data   = rgb_q[7:0];

endmodule

// File: tb/tb_vga_lane_overlay.sv
// Bench for vga_lane_overlay on a shrunk raster: scoreboard of
// per-pixel expectations plus tables of fixed address/colour points.
module tb_vga_lane_overlay;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VA = 12, VFP = 1, VSY = 2, VBP = 2;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int P = 2, NL = 4;
  localparam int LX0 = 1, LP = 4, LW = 3;
  localparam int LY0 = 3, LH = 4, FF = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] scr = 2'd0;
  logic [7:0] lanes = 8'd0;
  logic [23:0] pix = 24'd0;
  logic [18:0] addr;
  logic [1:0] oscr;
  logic hs, vs, bl;
  logic [7:0] b_o, g_o, r_o;

  always #5 clk = ~clk;

  vga_lane_overlay #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .PIX_LAT(P), .NUM_LANES(NL),
    .LANE_X0(LX0), .LANE_PITCH(LP), .LANE_W(LW),
    .LANE_Y0(LY0), .LANE_H(LH), .FLASH_FRAMES(FF)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iScreen(scr),
    .iLanes(lanes), .iPixel_bgr(pix), .oADDR(addr),
    .oScreen(oscr), .oHS(hs), .oVS(vs), .oBLANK_n(bl),
    .b_data(b_o), .g_data(g_o), .r_data(r_o)
  );

  typedef struct {
    int x; int y; logic [18:0] a;
    bit act; bit hs; bit vs;
  } ent_t;
  typedef struct { int x; int y; logic [18:0] a; } at_t;
  typedef struct { int x; int y; logic [23:0] c; bit bg; } pt_t;

  ent_t sbq[$];
  logic [18:0] romq[$];
  at_t atab[5];
  pt_t ptab[11];

  int mh, mv;
  logic [18:0] maddr;
  logic [1:0] mscr;
  int mfl[NL];
  logic [7:0] mln;
  int n_chk = 0, n_fail = 0;
  int hs_lo, vs_lo, bl_hi;
  bit have_full;
  int last_x, last_y;
  logic [23:0] last_rgb;
  int white;

  function automatic logic [23:0] rom(input logic [18:0] a);
    return (24'(a) * 24'd40503) ^ 24'h5A3C96;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic ent_t cur_ent();
    ent_t e;
    e.x = mh; e.y = mv; e.a = maddr;
    e.act = (mh < HA) && (mv < VA);
    e.hs = !(mh >= HA + HFP && mh < HA + HFP + HSY);
    e.vs = !(mv >= VA + VFP && mv < VA + VFP + VSY);
    return e;
  endfunction

  function automatic logic [23:0] exp_rgb(input ent_t e);
    int x0;
    if (!e.act) return 24'h0;
    for (int i = 0; i < NL; i++) begin
      x0 = LX0 + i * LP;
      if (e.x >= x0 && e.x < x0 + LW &&
          e.y >= LY0 && e.y < LY0 + LH) begin
        if (mfl[i] != 0) return 24'hFFFFFF;
        case (mln[2*i +: 2])
          2'd3: return 24'h006400;
          2'd2: return 24'h32CD32;
          2'd1: return 24'h90EE90;
          default: return rom(e.a);
        endcase
      end
    end
    return rom(e.a);
  endfunction

  task automatic model_init();
    ent_t z;
    mh = 0; mv = 0; maddr = '0; mscr = '0; mln = '0;
    for (int i = 0; i < NL; i++) mfl[i] = 0;
    z.x = -1; z.y = -1; z.a = '0;
    z.act = 1'b0; z.hs = 1'b1; z.vs = 1'b1;
    sbq.delete();
    for (int i = 0; i < P; i++) sbq.push_back(z);
    sbq.push_back(cur_ent());
    romq.delete();
    for (int i = 0; i < P; i++) romq.push_back(19'd0);
    pix = 24'd0;
    have_full = 0; hs_lo = 0; vs_lo = 0; bl_hi = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " hs"}, 32'(hs), 32'd1);
    chk({tag, " vs"}, 32'(vs), 32'd1);
    chk({tag, " blank"}, 32'(bl), 32'd0);
    chk({tag, " rgb"}, {8'd0, b_o, g_o, r_o}, 32'd0);
    chk({tag, " addr"}, 32'(addr), 32'd0);
    chk({tag, " screen"}, 32'(oscr), 32'd0);
  endtask

  task automatic tick();
    ent_t e;
    logic [23:0] got;
    bit fe;
    string pos;
    @(negedge clk);
    e = sbq.pop_front();
    got = {b_o, g_o, r_o};
    pos = $sformatf("(%0d,%0d)", e.x, e.y);
    chk({"rgb", pos}, 32'(got), 32'(exp_rgb(e)));
    chk({"hs", pos}, 32'(hs), 32'(e.hs));
    chk({"vs", pos}, 32'(vs), 32'(e.vs));
    chk({"blank", pos}, 32'(bl), 32'(e.act));
    last_x = e.x; last_y = e.y; last_rgb = got;
    if (e.x == 0 && e.y == 0) begin
      if (have_full) begin
        chk("hs low per frame", hs_lo, HSY * VT);
        chk("vs low per frame", vs_lo, VSY * HT);
        chk("blank high per frame", bl_hi, HA * VA);
      end
      have_full = 1; hs_lo = 0; vs_lo = 0; bl_hi = 0;
    end
    if (!hs) hs_lo++;
    if (!vs) vs_lo++;
    if (bl) bl_hi++;
    fe = (mh == HT - 1) && (mv == VT - 1);
    if (fe) maddr = '0;
    else if (mh < HA && mv < VA) maddr = maddr + 19'd1;
    if (fe) mscr = scr;
    for (int i = 0; i < NL; i++) begin
      if (fe && mfl[i] != 0) mfl[i]--;
      if (mln[2*i +: 2] == 2'd0 && lanes[2*i +: 2] != 2'd0)
        mfl[i] = FF;
    end
    mln = lanes;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else mh++;
    sbq.push_back(cur_ent());
    chk("addr", 32'(addr), 32'(maddr));
    chk("screen", 32'(oscr), 32'(mscr));
    for (int i = 0; i < 5; i++)
      if (atab[i].x == mh && atab[i].y == mv)
        chk($sformatf("addr at (%0d,%0d)", mh, mv),
            32'(addr), 32'(atab[i].a));
    romq.push_back(addr);
    pix = rom(romq.pop_front());
  endtask

  task automatic to_model(input int x, input int y);
    int n;
    n = 0;
    do begin tick(); n++; end
    while (!(mh == x && mv == y) && n < 2 * HT * VT);
    if (!(mh == x && mv == y)) begin
      n_chk++; n_fail++;
      $display("FAIL timeout model (%0d,%0d)", x, y);
    end
  endtask

  task automatic to_out(input int x, input int y);
    int n;
    n = 0;
    do begin tick(); n++; end
    while (!(last_x == x && last_y == y) && n < 2 * HT * VT);
    if (!(last_x == x && last_y == y)) begin
      n_chk++; n_fail++;
      $display("FAIL timeout output (%0d,%0d)", x, y);
    end
  endtask

  initial begin
    atab[0] = '{0, 0, 19'd0};
    atab[1] = '{15, 0, 19'd15};
    atab[2] = '{0, 1, 19'd16};
    atab[3] = '{15, 11, 19'd191};
    atab[4] = '{5, 5, 19'd85};
    ptab[0]  = '{6, 2, 24'h0, 1'b1};
    ptab[1]  = '{1, 3, 24'h0, 1'b1};
    ptab[2]  = '{4, 3, 24'h0, 1'b1};
    ptab[3]  = '{5, 3, 24'h32CD32, 1'b0};
    ptab[4]  = '{13, 3, 24'h006400, 1'b0};
    ptab[5]  = '{8, 4, 24'h0, 1'b1};
    ptab[6]  = '{9, 4, 24'h90EE90, 1'b0};
    ptab[7]  = '{7, 6, 24'h32CD32, 1'b0};
    ptab[8]  = '{11, 6, 24'h90EE90, 1'b0};
    ptab[9]  = '{15, 6, 24'h006400, 1'b0};
    ptab[10] = '{5, 7, 24'h0, 1'b1};

    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    model_init();
    #1 rst_n = 1'b1;

    repeat (3) to_model(0, 0);

    lanes = 8'b11_01_10_00;
    repeat (FF + 1) to_model(0, 0);
    for (int i = 0; i < 11; i++) begin
      to_out(ptab[i].x, ptab[i].y);
      chk($sformatf("lane px (%0d,%0d)", ptab[i].x, ptab[i].y),
          32'(last_rgb),
          32'(ptab[i].bg ? rom(19'(ptab[i].y * HA + ptab[i].x))
                         : ptab[i].c));
    end

    to_model(8, 8);
    lanes[1:0] = 2'd3;
    white = 0;
    for (int k = 1; k <= 5; k++) begin
      to_out(1, 3);
      if (last_rgb == 24'hFFFFFF) white++;
      if (k == 5) chk("lane0 after flash", 32'(last_rgb), 32'h90EE90);
      if (k == 1) begin
        to_model(8, 8);
        lanes[1:0] = 2'd0;
        repeat (3) tick();
        lanes[1:0] = 2'd1;
      end
    end
    chk("white frames with rehit", white, 3);

    to_model(5, 5);
    scr = 2'd3;
    to_model(HT - 1, VT - 1);
    chk("screen before frame end", 32'(oscr), 32'd0);
    tick();
    chk("screen after frame end", 32'(oscr), 32'd3);

    to_model(8, 6);
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("async reset");
    @(negedge clk);
    model_init();
    #1 rst_n = 1'b1;
    repeat (2) to_model(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
